// File: rtl/sys_mem_host.sv
// Host-side initiator for the system memory-control port: preloads a program image,
// runs the CPU until halt or timeout, then streams a fixed memory window out.
module sys_mem_host #(
   parameter logic [31:0] LOAD_BASE    = 32'h0,
   parameter logic [31:0] DUMP_BASE    = 32'h0,
   parameter int unsigned DUMP_WORDS   = 1024,
   parameter logic [31:0] HALT_TIMEOUT = 32'd1000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        tbCTRL,
   output logic        WEN,
   output logic        REN,
   output logic [31:0] addr,
   output logic [31:0] store,
   input  logic [31:0] load,
   input  logic [1:0]  ramstate,
   input  logic        halt,
   output logic        cpu_nRST,
   output logic        dump_valid,
   output logic [31:0] dump_addr,
   output logic [31:0] dump_data,
   input  logic        dump_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        timeout
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_ACC, S_LOAD_WR, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
   } state_t;

   localparam logic [1:0]  RS_ACCESS = 2'd2;
   localparam logic [1:0]  RS_ERROR  = 2'd3;
   localparam logic [15:0] DUMP_CNT  = 16'(DUMP_WORDS);

   state_t      state_q, state_d;
   logic        tbctrl_q, tbctrl_d, wen_q, wen_d, ren_q, ren_d;
   logic        cpu_nrst_q, cpu_nrst_d, load_ready_q, load_ready_d;
   logic        dump_valid_q, dump_valid_d, busy_q, busy_d, done_q, done_d;
   logic        err_q, err_d, timeout_q, timeout_d, last_q, last_d;
   logic [31:0] addr_q, addr_d, store_q, store_d, dump_addr_q, dump_addr_d;
   logic [31:0] dump_data_q, dump_data_d, waddr_q, waddr_d, raddr_q, raddr_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] rem_q, rem_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         tbctrl_q     <= 1'b1;
         wen_q        <= 1'b0;
         ren_q        <= 1'b0;
         cpu_nrst_q   <= 1'b0;
         load_ready_q <= 1'b0;
         dump_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         last_q       <= 1'b0;
         addr_q       <= '0;
         store_q      <= '0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         waddr_q      <= '0;
         raddr_q      <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
      end else begin
         state_q      <= state_d;
         tbctrl_q     <= tbctrl_d;
         wen_q        <= wen_d;
         ren_q        <= ren_d;
         cpu_nrst_q   <= cpu_nrst_d;
         load_ready_q <= load_ready_d;
         dump_valid_q <= dump_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         timeout_q    <= timeout_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         store_q      <= store_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         waddr_q      <= waddr_d;
         raddr_q      <= raddr_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tbctrl_d     = tbctrl_q;
      wen_d        = wen_q;
      ren_d        = ren_q;
      cpu_nrst_d   = cpu_nrst_q;
      load_ready_d = load_ready_q;
      dump_valid_d = dump_valid_q;
      done_d       = done_q;
      err_d        = err_q;
      timeout_d    = timeout_q;
      last_d       = last_q;
      addr_d       = addr_q;
      store_d      = store_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      waddr_d      = waddr_q;
      raddr_d      = raddr_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_LOAD_ACC;
               done_d       = 1'b0;
               err_d        = 1'b0;
               timeout_d    = 1'b0;
               waddr_d      = LOAD_BASE;
               load_ready_d = 1'b1;
            end
         end
         S_LOAD_ACC: begin
            if (load_valid && load_ready_q) begin
               store_d      = load_data;
               addr_d       = waddr_q;
               wen_d        = 1'b1;
               load_ready_d = 1'b0;
               last_d       = load_last;
               state_d      = S_LOAD_WR;
            end
         end
         S_LOAD_WR: begin
            if (ramstate == RS_ACCESS) begin
               wen_d   = 1'b0;
               waddr_d = waddr_q + 32'd4;
               if (last_q) begin
                  state_d    = S_RUN;
                  tbctrl_d   = 1'b0;
                  cpu_nrst_d = 1'b1;
                  cnt_d      = '0;
               end else begin
                  state_d      = S_LOAD_ACC;
                  load_ready_d = 1'b1;
               end
            end else if (ramstate == RS_ERROR) begin
               wen_d   = 1'b0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RUN: begin
            // Halt wins over a timeout landing on the same cycle.
            if (halt) begin
               state_d    = S_DUMP_RD;
               cpu_nrst_d = 1'b0;
               tbctrl_d   = 1'b1;
               raddr_d    = DUMP_BASE;
               rem_d      = DUMP_CNT;
               ren_d      = 1'b1;
               addr_d     = DUMP_BASE;
            end else if (cnt_q == HALT_TIMEOUT - 32'd1) begin
               timeout_d  = 1'b1;
               done_d     = 1'b1;
               cpu_nrst_d = 1'b0;
               tbctrl_d   = 1'b1;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DUMP_RD: begin
            if (ramstate == RS_ACCESS) begin
               dump_data_d  = load;
               dump_addr_d  = raddr_q;
               ren_d        = 1'b0;
               dump_valid_d = 1'b1;
               state_d      = S_DUMP_OUT;
            end else if (ramstate == RS_ERROR) begin
               ren_d   = 1'b0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DUMP_OUT: begin
            if (dump_ready && dump_valid_q) begin
               dump_valid_d = 1'b0;
               raddr_d      = raddr_q + 32'd4;
               rem_d        = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DUMP_RD;
                  ren_d   = 1'b1;
                  addr_d  = raddr_q + 32'd4;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   assign load_ready = load_ready_q;
   assign tbCTRL     = tbctrl_q;
   assign WEN        = wen_q;
   assign REN        = ren_q;
   assign addr       = addr_q;
   assign store      = store_q;
   assign cpu_nRST   = cpu_nrst_q;
   assign dump_valid = dump_valid_q;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign timeout    = timeout_q;
endmodule
